// File: rtl/traffic_phase_controller_pkg.sv
// Shared types for the traffic phase controller: state encodings, interval selects, lamp codes
// and the per-state output table used by the sequencer.
package tlc_pkg;

    typedef enum logic [2:0] {
        MAIN_G     = 3'd0,
        MAIN_Y     = 3'd1,
        WALK       = 3'd2,
        SIDE_G     = 3'd3,
        SIDE_G_EXT = 3'd4,
        SIDE_Y     = 3'd5
    } tlc_state_e;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] main_light;
        logic [2:0] side_light;
        logic       walk_lamp;
    } tlc_out_t;

    // Everything starts all-red so a state can only open one road explicitly.
    function automatic tlc_out_t state_outputs(tlc_state_e s);
        tlc_out_t o;
        o.sel        = SEL_BASE;
        o.main_light = LAMP_R;
        o.side_light = LAMP_R;
        o.walk_lamp  = 1'b0;
        case (s)
            MAIN_G: o.main_light = LAMP_G;
            MAIN_Y: begin
                o.sel        = SEL_YEL;
                o.main_light = LAMP_Y;
            end
            WALK: begin
                o.sel       = SEL_EXT;
                o.walk_lamp = 1'b1;
            end
            SIDE_G: o.side_light = LAMP_G;
            SIDE_G_EXT: begin
                o.sel        = SEL_EXT;
                o.side_light = LAMP_G;
            end
            SIDE_Y: begin
                o.sel        = SEL_YEL;
                o.side_light = LAMP_Y;
            end
            default: o.main_light = LAMP_G;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// Signal bundle between the phase controller (master) and the Timer / sensors / lamp drivers (slave).
interface traffic_phase_controller_if;

    logic       expired;
    logic       sensor;
    logic       walk_request;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;
    logic [2:0] phase;

    modport master (
        input  expired, sensor, walk_request,
        output start_timer, interval_sel, main_light, side_light, walk_lamp, phase
    );

    modport slave (
        output expired, sensor, walk_request,
        input  start_timer, interval_sel, main_light, side_light, walk_lamp, phase
    );

endinterface

// File: rtl/traffic_phase_controller_start_arm.sv
// Registers the one-cycle Timer start pulse and re-arms expiry acceptance BLANK_CYCLES cycles
// after the pulse falls, hiding the Timer's reload latency from the sequencer.
module tlc_start_arm #(
    parameter int unsigned BLANK_CYCLES = 1   // legal 1..3
) (
    input  logic clk,
    input  logic reset_global,
    input  logic i_phase_entry,
    output logic o_start_timer,
    output logic o_armed
);

    localparam logic [1:0] LP_LAST = 2'(BLANK_CYCLES - 1);

    logic       r_start_timer;
    logic       r_armed;
    logic [1:0] r_blank_cnt;

    // NOTE: non-blocking assignments here so every register samples pre-edge values; blocking
    // would let later statements see this edge's updates and skew the pulse/arm timing.
    always_ff @(posedge clk) begin
        if (!reset_global) begin
            r_start_timer <= 1'b0;
            r_armed       <= 1'b0;
            r_blank_cnt   <= 2'd0;
        end else begin
            r_start_timer <= i_phase_entry;
            if (i_phase_entry || r_start_timer) begin
                r_armed     <= 1'b0;
                r_blank_cnt <= 2'd0;
            end else if (!r_armed) begin
                if (r_blank_cnt == LP_LAST) begin
                    r_armed <= 1'b1;
                end else begin
                    r_blank_cnt <= r_blank_cnt + 2'd1;
                end
            end
        end
    end

    assign o_start_timer = r_start_timer;
    assign o_armed       = r_armed;

endmodule

// File: rtl/traffic_phase_controller.sv
// Main sequencing FSM of the traffic light controller: steps through the phases on Timer expiry.
// Define TLC_WALK_EN to build the pedestrian WALK phase; otherwise walk_request is ignored.
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 1   // legal 1..3
) (
    input  logic                        clk,
    input  logic                        reset_global,
    traffic_phase_controller_if.master  bus
);

    tlc_state_e r_state;
    tlc_out_t   r_out;
    logic       r_kick;
    logic       r_sensor_pend;
`ifdef TLC_WALK_EN
    logic       r_walk_pend;
`endif

    tlc_state_e w_next;
    logic       w_legal;
    logic       w_armed;
    logic       w_start_timer;
    logic       w_take;
    logic       w_phase_entry;

    tlc_start_arm #(
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_start_arm (
        .clk           (clk),
        .reset_global  (reset_global),
        .i_phase_entry (w_phase_entry),
        .o_start_timer (w_start_timer),
        .o_armed       (w_armed)
    );

    // NOTE: defaults are assigned first so no path leaves an output unassigned (no latch).
    always_comb begin
        w_next  = MAIN_G;
        w_legal = 1'b1;
        case (r_state)
            MAIN_G:     w_next = r_sensor_pend ? MAIN_Y : MAIN_G;
`ifdef TLC_WALK_EN
            MAIN_Y:     w_next = r_walk_pend ? WALK : SIDE_G;
            WALK:       w_next = SIDE_G;
`else
            MAIN_Y:     w_next = SIDE_G;
`endif
            SIDE_G:     w_next = bus.sensor ? SIDE_G_EXT : SIDE_Y;
            SIDE_G_EXT: w_next = SIDE_Y;
            SIDE_Y:     w_next = MAIN_G;
            default: begin
                w_next  = MAIN_G;
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_take        = w_armed & bus.expired;
    assign w_phase_entry = r_kick | w_take | ~w_legal;

    always_ff @(posedge clk) begin
        if (!reset_global) begin
            r_state       <= MAIN_G;
            r_out         <= state_outputs(MAIN_G);
            r_kick        <= 1'b1;
            r_sensor_pend <= 1'b0;
`ifdef TLC_WALK_EN
            r_walk_pend   <= 1'b0;
`endif
        end else begin
            r_kick <= 1'b0;
            if (w_take || !w_legal) begin
                r_state <= w_next;
                r_out   <= state_outputs(w_next);
            end

            // Set beats clear: a request seen on the exit edge is kept for the next round.
            if (r_state == MAIN_G && bus.sensor) begin
                r_sensor_pend <= 1'b1;
            end else if (w_take && w_next == MAIN_Y) begin
                r_sensor_pend <= 1'b0;
            end
`ifdef TLC_WALK_EN
            if (r_state != WALK && bus.walk_request) begin
                r_walk_pend <= 1'b1;
            end else if (r_state == WALK && w_take) begin
                r_walk_pend <= 1'b0;
            end
`endif
        end
    end

    assign bus.start_timer  = w_start_timer;
    assign bus.interval_sel = r_out.sel;
    assign bus.main_light   = r_out.main_light;
    assign bus.side_light   = r_out.side_light;
    assign bus.phase        = r_state;
`ifdef TLC_WALK_EN
    assign bus.walk_lamp    = r_out.walk_lamp;
`else
    logic w_unused_walk;
    assign w_unused_walk    = r_out.walk_lamp ^ bus.walk_request;
    assign bus.walk_lamp    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with a behavioural Timer (BASE=6, EXT=3, YEL=2,
// 1-in-4 enable) and a phase-rule model compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_traffic_phase_controller;
    import tlc_pkg::*;

    localparam int unsigned BLANK = 1;
    localparam int BASE_T = 6;
    localparam int EXT_T  = 3;
    localparam int YEL_T  = 2;
`ifdef TLC_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_global = 1'b0;
    logic force_exp = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    traffic_phase_controller_if bus ();

    traffic_phase_controller #(
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .reset_global (reset_global),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Timer plus time-parameter lookup; not reset, as in the real system.
    int tcount = 0;
    int en_div = 0;
    function automatic int interval_len(logic [1:0] sel);
        case (sel)
            2'b00:   return BASE_T;
            2'b01:   return EXT_T;
            2'b10:   return YEL_T;
            default: return 0;
        endcase
    endfunction
    always @(posedge clk) begin
        en_div <= (en_div + 1) % 4;
        if (bus.start_timer === 1'b1) tcount <= interval_len(bus.interval_sel);
        else if (en_div == 3 && tcount != 0) tcount <= tcount - 1;
    end
    assign bus.expired = force_exp | (tcount == 0);

    // Phase-rule model: phases numbered as encoded, outputs from per-phase tables.
    int sel_tab  [6] = '{0, 2, 1, 0, 1, 2};
    int main_tab [6] = '{1, 2, 4, 4, 4, 4};
    int side_tab [6] = '{4, 4, 4, 1, 1, 2};
    int m_phase = 0;
    int m_since = 0;
    bit m_start = 1'b0;
    bit m_kick  = 1'b0;
    bit m_spend = 1'b0;
    bit m_wpend = 1'b0;
    bit m_valid = 1'b0;
    bit m_fire;
    int m_next;

    function automatic int next_phase(int p, bit spend, bit wpend, logic sens);
        case (p)
            0:       return spend ? 1 : 0;
            1:       return (WALK_EN && wpend) ? 2 : 3;
            2:       return 3;
            3:       return (sens === 1'b1) ? 4 : 5;
            4:       return 5;
            5:       return 0;
            default: return 0;
        endcase
    endfunction

    // An expiry counts once BLANK+2 edges have passed since the entry edge.
    always_comb begin
        m_fire = m_kick || (bus.expired === 1'b1 && m_since >= int'(BLANK) + 1);
        m_next = m_kick ? 0 : next_phase(m_phase, m_spend, m_wpend, bus.sensor);
    end

    always @(posedge clk) begin
        if (!reset_global) begin
            m_valid <= 1'b1;
            m_phase <= 0;
            m_start <= 1'b0;
            m_since <= 0;
            m_kick  <= 1'b1;
            m_spend <= 1'b0;
            m_wpend <= 1'b0;
        end else begin
            m_kick  <= 1'b0;
            m_start <= m_fire;
            if (m_fire) begin
                m_phase <= m_next;
                m_since <= 0;
            end else begin
                m_since <= m_since + 1;
            end
            if (m_phase == 0 && bus.sensor === 1'b1) m_spend <= 1'b1;
            else if (m_fire && m_next == 1) m_spend <= 1'b0;
            if (WALK_EN && m_phase != 2 && bus.walk_request === 1'b1) m_wpend <= 1'b1;
            else if (m_fire && m_phase == 2) m_wpend <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_phase",        32'(bus.phase),        32'(m_phase));
            check("model_start_timer",  32'(bus.start_timer),  32'(m_start));
            check("model_interval_sel", 32'(bus.interval_sel), 32'(sel_tab[m_phase]));
            check("model_main_light",   32'(bus.main_light),   32'(main_tab[m_phase]));
            check("model_side_light",   32'(bus.side_light),   32'(side_tab[m_phase]));
            check("model_walk_lamp",    32'(bus.walk_lamp),    32'(WALK_EN && m_phase == 2));
            check("no_conflict", 32'(bus.main_light != LAMP_R && bus.side_light != LAMP_R), 32'd0);
        end
    end

    task automatic wait_start(output int ph);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.start_timer === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("start_seen", 32'(seen), 32'd1);
        ph = int'(bus.phase);
    endtask

    task automatic expect_phase(input string name, input int exp);
        int ph;
        wait_start(ph);
        check(name, 32'(ph), 32'(exp));
    endtask

    initial begin
        int ph;
        int t_prev;
        bus.sensor       = 1'b0;
        bus.walk_request = 1'b0;
        reset_global     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_phase", 32'(bus.phase), 32'd0);
        check("rst_start", 32'(bus.start_timer), 32'd0);
        check("rst_sel",   32'(bus.interval_sel), 32'd0);
        check("rst_main",  32'(bus.main_light), 32'b001);
        check("rst_side",  32'(bus.side_light), 32'b100);
        check("rst_walk",  32'(bus.walk_lamp), 32'd0);

        reset_global = 1'b1;
        @(negedge clk);
        check("kick_start", 32'(bus.start_timer), 32'd1);
        check("kick_sel",   32'(bus.interval_sel), 32'd0);
        check("kick_main",  32'(bus.main_light), 32'b001);
        check("kick_side",  32'(bus.side_light), 32'b100);
        @(negedge clk);
        check("kick_one_cycle", 32'(bus.start_timer), 32'd0);

        // No sensor: MAIN_G re-enters on every expiry.
        for (int k = 0; k < 3; k++) begin
            expect_phase("idle_main_g", 0);
            check("idle_main", 32'(bus.main_light), 32'b001);
            check("idle_side", 32'(bus.side_light), 32'b100);
        end

        // Single-cycle sensor pulse.
        repeat (5) @(negedge clk);
        bus.sensor = 1'b1;
        @(negedge clk);
        bus.sensor = 1'b0;
        expect_phase("pulse_main_y", 1);
        check("pulse_main_y_sel", 32'(bus.interval_sel), 32'b10);
        expect_phase("pulse_side_g", 3);
        check("pulse_side_g_sel", 32'(bus.interval_sel), 32'b00);
        expect_phase("pulse_side_y", 5);
        expect_phase("pulse_main_g", 0);

        // Sensor held through MAIN_G exit and SIDE_G expiry; set-wins keeps one more request.
        repeat (3) @(negedge clk);
        bus.sensor = 1'b1;
        expect_phase("hold_main_y", 1);
        expect_phase("hold_side_g", 3);
        expect_phase("hold_side_g_ext", 4);
        check("ext_sel",  32'(bus.interval_sel), 32'b01);
        check("ext_main", 32'(bus.main_light), 32'b100);
        check("ext_side", 32'(bus.side_light), 32'b001);
        expect_phase("hold_side_y", 5);
        bus.sensor = 1'b0;
        expect_phase("hold_main_g", 0);
        expect_phase("kept_main_y", 1);
        expect_phase("kept_side_g", 3);
        expect_phase("kept_side_y", 5);
        expect_phase("kept_main_g", 0);

        // Pedestrian request plus sensor.
        repeat (4) @(negedge clk);
        bus.walk_request = 1'b1;
        bus.sensor       = 1'b1;
        @(negedge clk);
        bus.walk_request = 1'b0;
        bus.sensor       = 1'b0;
        expect_phase("walk_main_y", 1);
`ifdef TLC_WALK_EN
        expect_phase("walk_walk", 2);
        check("walk_main", 32'(bus.main_light), 32'b100);
        check("walk_side", 32'(bus.side_light), 32'b100);
        check("walk_lamp", 32'(bus.walk_lamp), 32'd1);
        check("walk_sel",  32'(bus.interval_sel), 32'b01);
`endif
        expect_phase("walk_side_g", 3);
        check("walk_lamp_off", 32'(bus.walk_lamp), 32'd0);
        expect_phase("walk_side_y", 5);
        expect_phase("walk_main_g", 0);

        // Expired stuck high: one advance every BLANK+2 cycles, no skips.
        force_exp = 1'b1;
        wait_start(ph);
        check("force_first", 32'(ph), 32'd0);
        t_prev = cyc;
        for (int k = 0; k < 3; k++) begin
            expect_phase("force_main_g", 0);
            check("force_period", 32'(cyc - t_prev), 32'd3);
            t_prev = cyc;
        end
        bus.sensor = 1'b1;
        @(negedge clk);
        bus.sensor = 1'b0;
        expect_phase("force_main_y", 1);
        check("force_period_y", 32'(cyc - t_prev), 32'd3);
        t_prev = cyc;
        expect_phase("force_side_g", 3);
        check("force_period_sg", 32'(cyc - t_prev), 32'd3);
        t_prev = cyc;
        expect_phase("force_side_y", 5);
        check("force_period_sy", 32'(cyc - t_prev), 32'd3);

        // Reset in the middle of SIDE_Y.
        reset_global = 1'b0;
        @(negedge clk);
        check("midrst_phase", 32'(bus.phase), 32'd0);
        check("midrst_start", 32'(bus.start_timer), 32'd0);
        check("midrst_main",  32'(bus.main_light), 32'b001);
        check("midrst_side",  32'(bus.side_light), 32'b100);
        force_exp    = 1'b0;
        reset_global = 1'b1;
        @(negedge clk);
        check("midrst_kick", 32'(bus.start_timer), 32'd1);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Main sequencing FSM of the traffic light controller.
- Walks the intersection through its phases and drives the lamp outputs for the main road and the side road.
- At each phase entry, selects an interval for the time-parameter block and fires a one-cycle start_timer pulse into the Timer.
- Advances to the next phase when the Timer raises expired; the side-road sensor and pedestrian requests steer the phase choices.

Parameters:
- BLANK_CYCLES, 1, cycles after a start_timer pulse during which expired is ignored, to cover the Timer reload latency. Legal range 1..3.

Ports:
- clk  in  1  system clock
- reset_global  in  1  synchronous, active-low reset
- expired  in  1  Timer done flag, level
- sensor  in  1  side-road vehicle present, level, already synchronised
- walk_request  in  1  pedestrian button, already synchronised
- start_timer  out  1  one-cycle load/start pulse to the Timer
- interval_sel  out  2  interval index to the time-parameter block: 00 BASE, 01 EXT, 10 YEL, 11 reserved and never driven
- main_light  out  3  {R,Y,G}, exactly one bit set
- side_light  out  3  {R,Y,G}, exactly one bit set
- walk_lamp  out  1  pedestrian walk indication
- phase  out  3  current state encoding, for debug and bench

Behaviour:
- All outputs are registered.
- Reset (reset_global==0 at a clk edge):
  - state=MAIN_G, start_timer=0, interval_sel=00.
  - main_light=001, side_light=100, walk_lamp=0.
  - sensor_pend=0, walk_pend=0, armed=0, kick=1.
- First cycle after reset release: start_timer=1 with interval_sel=00 (the kick flag), then kick clears.
- Phase entry: in the cycle after a transition, phase, lamps and interval_sel carry the new state's values and start_timer=1 for exactly one cycle.
  - interval_sel is valid in the same cycle as start_timer; the time-parameter lookup is combinational.
- Arming:
  - armed clears on start_timer.
  - armed sets BLANK_CYCLES cycles after start_timer falls.
  - expired is honoured only while armed==1. A stale expired from the previous interval must never cause a skip.
- States, interval and lamps (main/side):
  - MAIN_G: BASE; G/R.
    - On expired, go to MAIN_Y if sensor_pend==1.
    - Otherwise re-enter MAIN_G: new start_timer pulse, lamps unchanged.
  - MAIN_Y: YEL; Y/R. On expired, go to WALK if walk_pend==1, else go to SIDE_G.
  - WALK: EXT; R/R, walk_lamp=1. On expired, go to SIDE_G; walk_pend clears on exit.
  - SIDE_G: BASE; R/G. On expired, go to SIDE_G_EXT if sensor==1 in that cycle, else go to SIDE_Y.
  - SIDE_G_EXT: EXT; R/G. On expired, go to SIDE_Y.
  - SIDE_Y: YEL; R/Y. On expired, go to MAIN_G.
- Pending flags:
  - sensor_pend sets on any cycle with sensor==1 while in MAIN_G, and clears on entry to MAIN_Y.
  - walk_pend sets on walk_request==1 in any state except WALK.
  - If set and clear coincide, set wins; the request is kept for the next cycle of phases.
- The two roads never show non-red at the same time. Any encoding outside the six legal states recovers to MAIN_G with a start pulse.
- Reset mid-phase aborts immediately to the reset values. Any Timer countdown in flight is overridden by the kick pulse.

Optional Feature:
- Macro: TLC_WALK_EN.
- Defined:
  - WALK state exists, walk_pend latches walk_request, walk_lamp is driven as described above.
- Undefined:
  - WALK state, walk_pend and its logic are compiled out.
  - walk_request is ignored and walk_lamp is tied to 0.
  - MAIN_Y always goes to SIDE_G.
  - The WALK encoding is treated as illegal and recovers to MAIN_G.

Decomposition:
- Package tlc_pkg holds:
  - the state typedef and 3-bit encodings: MAIN_G=0, MAIN_Y=1, WALK=2, SIDE_G=3, SIDE_G_EXT=4, SIDE_Y=5;
  - interval_sel constants SEL_BASE, SEL_EXT, SEL_YEL;
  - lamp constants LAMP_R=100, LAMP_Y=010, LAMP_G=001.
- One sub-module, tlc_start_arm: start-pulse generator plus BLANK_CYCLES arm counter. Inputs: phase_entry, clk, reset. Outputs: start_timer, armed.

Test Plan (bench uses the real Timer and time-parameter block with BASE=6, EXT=3, YEL=2, and a 1-in-4 enable_1Hz):
- Reset held 2 cycles, then released -> start_timer high exactly 1 cycle after release with interval_sel=00; main_light=001, side_light=100.
- No sensor for 3 BASE intervals -> phase stays MAIN_G; one start_timer pulse per expiry; lamps never change.
- sensor pulsed 1 cycle mid MAIN_G -> at expiry, MAIN_Y (sel=10), then SIDE_G (sel=00); sensor low at SIDE_G expiry -> SIDE_Y -> MAIN_G.
- sensor held high through SIDE_G expiry -> SIDE_G_EXT with interval_sel=01, then SIDE_Y.
- With TLC_WALK_EN defined: walk_request during MAIN_G plus sensor -> after MAIN_Y, WALK with both lamps 100, walk_lamp=1, sel=01, then SIDE_G. Without the macro, the same stimulus goes straight to SIDE_G and walk_lamp stays 0.
- expired forced high continuously -> exactly one phase advance per BLANK_CYCLES+2 cycles; no state skipped; reset asserted mid SIDE_Y -> MAIN_G next cycle.
